// File: rtl/parking_gate_ctrl.sv
// Car-park entry gate controller: password-checked admission, occupancy
// tracking with full detection, free-bay 7-segment display and wrong-code lockout.
module parking_gate_ctrl #(
  parameter int unsigned     PW_W      = 4,
  parameter logic [PW_W-1:0] PASSWORD  = 4'hB,
  parameter int unsigned     CAPACITY  = 9,
  parameter int unsigned     WAIT_CYC  = 3,
  parameter int unsigned     MAX_TRIES = 3,
  parameter int unsigned     LOCK_CYC  = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            sensor_entrance,
  input  logic            sensor_exit,
  input  logic            car_leave,
  input  logic [PW_W-1:0] password,
  input  logic            pass_valid,
  output logic            GREEN_LED,
  output logic            RED_LED,
  output logic            gate_open,
  output logic            locked,
  output logic            full,
  output logic [6:0]      occupancy,
  output logic [6:0]      HEX_1,
  output logic [6:0]      HEX_2
);

  localparam int unsigned WAIT_W = (WAIT_CYC  > 0) ? $clog2(WAIT_CYC + 1)  : 1;
  localparam int unsigned TRY_W  = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;
  localparam int unsigned LOCK_W = (LOCK_CYC  > 1) ? $clog2(LOCK_CYC)      : 1;

  typedef enum logic [2:0] {
    IDLE, WAIT_PASS, WRONG_PASS, RIGHT_PASS, STOP, LOCKOUT
  } state_t;

  state_t             state, state_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
  logic [TRY_W-1:0]   tries, tries_nxt, tries_inc;
  logic [LOCK_W-1:0]  lock_cnt, lock_nxt;
  logic               red_nxt;
  logic               code_ok;
  logic               eval;
  logic               occ_inc, occ_dec;
  logic [6:0]         free_bays;
  logic [3:0]         tens, ones;

  assign full = (occupancy == 7'(CAPACITY));

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    tries_nxt = tries;
    lock_nxt  = lock_cnt;
    eval      = 1'b0;
    code_ok   = (password == PASSWORD) && !full;
    tries_inc = tries + 1'b1;

    case (state)
      IDLE:
        if (sensor_entrance && !full) begin
          state_nxt = WAIT_PASS;
          wait_nxt  = '0;
        end
      WAIT_PASS: begin
        if (wait_cnt != WAIT_W'(WAIT_CYC)) wait_nxt = wait_cnt + 1'b1;
        if (wait_cnt == WAIT_W'(WAIT_CYC) && pass_valid) eval = 1'b1;
        else if (!sensor_entrance)                       state_nxt = IDLE;
      end
      WRONG_PASS: eval = pass_valid;
      // A correct code while full is neither accepted nor counted as a miss.
      STOP:       eval = pass_valid && !((password == PASSWORD) && full);
      RIGHT_PASS:
        if (sensor_exit) state_nxt = sensor_entrance ? STOP : IDLE;
      LOCKOUT:
        if (lock_cnt == LOCK_W'(LOCK_CYC - 1)) state_nxt = IDLE;
        else                                   lock_nxt  = lock_cnt + 1'b1;
      default: state_nxt = IDLE;
    endcase

    if (eval) begin
      if (code_ok) begin
        state_nxt = RIGHT_PASS;
        tries_nxt = '0;
      end else begin
        tries_nxt = tries_inc;
        if (tries_inc == TRY_W'(MAX_TRIES)) begin
          state_nxt = LOCKOUT;
          lock_nxt  = '0;
        end else begin
          state_nxt = WRONG_PASS;
        end
      end
    end

    if (state_nxt == IDLE) tries_nxt = '0;

    // RED_LED doubles as the blink register in WRONG_PASS/STOP.
    case (state_nxt)
      LOCKOUT:          red_nxt = 1'b1;
      WRONG_PASS, STOP: red_nxt = (state_nxt != state) ? 1'b1 : !RED_LED;
      IDLE:             red_nxt = (state == IDLE) && sensor_entrance && full;
      default:          red_nxt = 1'b0;
    endcase
  end

  assign occ_inc = (state == RIGHT_PASS) && sensor_exit;
  assign occ_dec = car_leave && (occupancy != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      tries     <= '0;
      lock_cnt  <= '0;
      occupancy <= '0;
      GREEN_LED <= 1'b0;
      RED_LED   <= 1'b0;
      gate_open <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      tries     <= tries_nxt;
      lock_cnt  <= lock_nxt;
      GREEN_LED <= (state_nxt == RIGHT_PASS);
      gate_open <= (state_nxt == RIGHT_PASS);
      locked    <= (state_nxt == LOCKOUT);
      RED_LED   <= red_nxt;
      if (occ_inc && !occ_dec)      occupancy <= occupancy + 1'b1;
      else if (occ_dec && !occ_inc) occupancy <= occupancy - 1'b1;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    free_bays = 7'(CAPACITY) - occupancy;
    tens      = 4'(free_bays / 7'd10);
    ones      = 4'(free_bays % 7'd10);
    HEX_1     = seg7(ones);
    HEX_2     = seg7(tens);
  end

endmodule
